medfilt_window_ctrl: RTL

- Frame sequencer for the 3x3 median-filter front end: line buffers (2 rows) plus the 3x3 window shift register.
- Accepts a raster pixel stream under valid/ready and tracks row/column position.
- Drives line-buffer address, write and rotation controls, the window shift enable and pad-injection strobes.
- Emits one window-valid per image pixel, tagged with border flags, so the downstream median sorter sees exactly IMG_HEIGHT*IMG_WIDTH windows per frame.

---
 rtl/medfilt_window_ctrl_pkg.sv | 22 ++
 rtl/medfilt_window_ctrl_if.sv | 33 +++
 rtl/medfilt_window_ctrl_pos_counter.sv | 47 ++++
 rtl/medfilt_window_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/medfilt_window_ctrl_pkg.sv
// Shared types for the 3x3 median-filter window controller and its testbench.
package medfilt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    PADCOL,
    PADROW,
    DONE
  } ctrl_state_e;

  // Value the datapath injects into the window whenever pad_ins is high.
  localparam logic [7:0] PAD_VALUE = 8'd0;

  typedef struct packed {
    logic top;
    logic bot;
    logic left;
    logic right;
  } win_flags_t;

endpackage

// File: rtl/medfilt_window_ctrl_if.sv
// Pixel handshake plus line-buffer/window control bundle between the sequencer and its datapath.
interface medfilt_window_ctrl_if #(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = $clog2(IMG_WIDTH + 1)
);
  logic             s_valid;
  logic             s_sof;
  logic             s_ready;
  logic [COL_W-1:0] lb_addr;
  logic             lb_wr_en;
  logic             lb_sel;
  logic             win_shift;
  logic             pad_ins;
  logic             win_valid;
  logic             win_top;
  logic             win_bot;
  logic             win_left;
  logic             win_right;
  logic             frame_done;
  logic             err_sof;

  modport master (
    output s_valid, s_sof,
    input  s_ready, lb_addr, lb_wr_en, lb_sel, win_shift, pad_ins, win_valid,
           win_top, win_bot, win_left, win_right, frame_done, err_sof
  );

  modport slave (
    input  s_valid, s_sof,
    output s_ready, lb_addr, lb_wr_en, lb_sel, win_shift, pad_ins, win_valid,
           win_top, win_bot, win_left, win_right, frame_done, err_sof
  );
endinterface

// File: rtl/medfilt_window_ctrl_pos_counter.sv
// Column/row position counters for the window sequencer, with terminal-count flags
// marking the last real column and the last real row.
module medfilt_pos_counter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH + 1),
  parameter int ROW_W      = $clog2(IMG_HEIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             col_en,
  input  logic             col_clr,
  input  logic             row_en,
  input  logic             row_clr,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_tc,
  output logic             row_tc
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT);

  // Clear wins; clear together with enable lands on 1 so a restarting pixel counts as column 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
    end else if (col_clr) begin
      col <= col_en ? COL_W'(1) : '0;
    end else if (col_en) begin
      col <= (col == COL_MAX) ? '0 : col + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
    end else if (row_clr) begin
      row <= '0;
    end else if (row_en) begin
      row <= (row == ROW_MAX) ? '0 : row + 1'b1;
    end
  end

  assign col_tc = (col == COL_W'(IMG_WIDTH - 1));
  assign row_tc = (row == ROW_W'(IMG_HEIGHT - 1));

endmodule

// File: rtl/medfilt_window_ctrl.sv
// Frame sequencer for the 3x3 median-filter front end: walks the raster, steers the
// line buffers and window register, and tags each real window centre with border flags.
module medfilt_window_ctrl
  import medfilt_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH + 1),
  parameter int ROW_W      = $clog2(IMG_HEIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  medfilt_window_ctrl_if.slave bus
);
  ctrl_state_e      state, state_n;
  logic [COL_W-1:0] col, lb_addr;
  logic [ROW_W-1:0] row;
  logic             col_tc, row_tc, col_en, col_clr, row_en, row_clr;
  logic             s_ready, accept, restart, sel_tgl, sel_clr, lb_sel;
  logic             win_shift, pad_ins, lb_wr_en, frame_done, err_sof;
  logic             valid_d, win_valid_q;
  win_flags_t       flags_d, flags_q;

  medfilt_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .col_en (col_en),
    .col_clr(col_clr),
    .row_en (row_en),
    .row_clr(row_clr),
    .col    (col),
    .row    (row),
    .col_tc (col_tc),
    .row_tc (row_tc)
  );

  assign s_ready = (state == IDLE) || (state == ROW);
  assign accept  = bus.s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    win_shift  = 1'b0;
    pad_ins    = 1'b0;
    lb_wr_en   = 1'b0;
    lb_addr    = col;
    frame_done = 1'b0;
    err_sof    = 1'b0;
    col_en     = 1'b0;
    col_clr    = 1'b0;
    row_en     = 1'b0;
    row_clr    = 1'b0;
    sel_tgl    = 1'b0;
    sel_clr    = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: restart = accept && bus.s_sof;
      ROW: begin
        if (accept && bus.s_sof) begin
          restart = 1'b1;
          err_sof = (row != '0) || (col != '0);
        end else if (accept) begin
          win_shift = 1'b1;
          lb_wr_en  = 1'b1;
          col_en    = 1'b1;
          if (col_tc) state_n = PADCOL;
        end
      end
      PADCOL: begin
        win_shift = 1'b1;
        pad_ins   = 1'b1;
        col_clr   = 1'b1;
        row_en    = 1'b1;
        sel_tgl   = 1'b1;
        state_n   = row_tc ? PADROW : ROW;
      end
      PADROW: begin
        win_shift = 1'b1;
        pad_ins   = 1'b1;
        col_en    = 1'b1;
        if (col == COL_W'(IMG_WIDTH)) state_n = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        col_clr    = 1'b1;
        row_clr    = 1'b1;
        sel_clr    = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A start-of-frame pixel, from IDLE or mid-frame, is written and shifted in as the new (0,0).
    if (restart) begin
      win_shift = 1'b1;
      lb_wr_en  = 1'b1;
      lb_addr   = '0;
      col_clr   = 1'b1;
      col_en    = 1'b1;
      row_clr   = 1'b1;
      sel_clr   = 1'b1;
      state_n   = ROW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lb_sel <= 1'b0;
    else if (sel_clr) lb_sel <= 1'b0;
    else if (sel_tgl) lb_sel <= ~lb_sel;
  end

  // A shift at (r,c) centres the window on (r-1,c-1), so only r,c >= 1 yields a real pixel.
  assign valid_d = win_shift && !restart && (row != '0) && (col != '0);

  always_comb begin
    flags_d = '0;
    if (valid_d) begin
      flags_d.top   = (row == ROW_W'(1));
      flags_d.bot   = (row == ROW_W'(IMG_HEIGHT));
      flags_d.left  = (col == COL_W'(1));
      flags_d.right = (col == COL_W'(IMG_WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      win_valid_q <= valid_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.lb_addr    = lb_addr;
  assign bus.lb_wr_en   = lb_wr_en;
  assign bus.lb_sel     = lb_sel;
  assign bus.win_shift  = win_shift;
  assign bus.pad_ins    = pad_ins;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_top    = flags_q.top;
  assign bus.win_bot    = flags_q.bot;
  assign bus.win_left   = flags_q.left;
  assign bus.win_right  = flags_q.right;
  assign bus.frame_done = frame_done;
  assign bus.err_sof    = err_sof;

endmodule
